gpio_responder: RTL
===================

Name: gpio_responder

Overview:
- Memory-mapped GPIO peripheral; responder on the SoC data bus, driven by the core load/store unit as initiator.
- Drives pin output values and output enables toward the top-level tristate buffers, which live outside this block.
- Samples external pins through synchronizers.
- Raises an edge-triggered interrupt toward the core.

Parameters:
- NUM_PINS, 16, number of GPIO pins handled; legal range 1..32.
- ADDR_WIDTH, 5, byte-address bits decoded inside the block's region.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- bus_en  input  1  access request, valid for one cycle.
- bus_we  input  1  1 = write, 0 = read.
- bus_addr  input  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- bus_be  input  4  byte enables for writes.
- bus_wr_data  input  32  write data.
- bus_rd_data  output  32  read data, valid when bus_rd_valid is high.
- bus_rd_valid  output  1  read response strobe.
- bus_err  output  1  unmapped-access strobe.
- gpio_i  input  NUM_PINS  raw pin inputs; asynchronous.
- gpio_o  output  NUM_PINS  pin output values.
- gpio_oe  output  NUM_PINS  output enable; 1 = drive the pin.
- irq  output  1  level interrupt; OR of all PEND bits.

Behaviour:
- Register map (byte offsets):
  - 0x00 MODE: rw; drives gpio_oe.
  - 0x04 OUT: rw; drives gpio_o.
  - 0x08 IN: ro; synchronized pin values.
  - 0x0C RISE_EN: rw.
  - 0x10 FALL_EN: rw.
  - 0x14 PEND: rw1c.
  - 0x18 OUT_SET: wo; OUT |= wdata.
  - 0x1C OUT_CLR: wo; OUT &= ~wdata.
- Bits at or above NUM_PINS read 0 and ignore writes.
- Reset values: MODE, OUT, RISE_EN, FALL_EN, PEND, sync flops, bus_rd_data, bus_rd_valid, bus_err, irq all 0. Reset asserted mid-access clears everything; no response is issued for a request in flight.
- Writes take effect on the clk edge where bus_en & bus_we is sampled. Byte lanes are gated by bus_be. gpio_o and gpio_oe update the following cycle, registered from the register state with no combinational path from the bus.
- Reads: bus_rd_valid pulses exactly one cycle after bus_en & !bus_we, with bus_rd_data registered. bus_rd_data returns 0 when bus_rd_valid is low.
  - OUT_SET and OUT_CLR read 0.
  - A read of IN returns the value held in the sync stage at the request cycle.
- Writes produce no response strobe.
- Unmapped offset (>= 0x20 within ADDR_WIDTH):
  - bus_err pulses one cycle after the request.
  - A read also pulses bus_rd_valid, with data 0.
  - Writes are ignored.
- Input path per pin: 2-flop synchronizer, then a prev flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - A pin change sampled at edge N appears in IN after edge N+2. The PEND bit sets at edge N+3, and irq is high in the cycle after N+3. irq is combinational from the PEND register.
- Edge detection is suppressed until 3 clocks after reset release, using a saturating 2-bit counter. This stops pins that are high at reset from setting PEND.
- PEND[i] sets when (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
- A W1C of PEND and a new edge on the same bit in the same cycle leave the bit set, because set wins.
- Clearing RISE_EN or FALL_EN does not clear an existing PEND bit.
- Simultaneous writes of OUT_SET and OUT_CLR cannot occur, since the bus carries one access per cycle.
- Back-to-back accesses are accepted every cycle; the block has no stall.

Decomposition:
- gpio_pkg holds:
  - register offset localparams (GPIO_MODE_OFS ... GPIO_OUT_CLR_OFS);
  - GPIO_NUM_REGS;
  - a typedef enum for the register index;
  - the 32-bit data typedef.
- Sub-module gpio_sync(WIDTH): synchronizer, prev flop, reset-release mask counter. It outputs sync_val, rise and fall vectors. It is instantiated once, vector-wide.

Test Plan:
1. Reset then read each register -> every read returns 0x00000000 with bus_rd_valid exactly 1 cycle after the request; gpio_oe = 0, gpio_o = 0, irq = 0.
2. Write MODE=0x00FF, OUT=0xA5A5, then OUT_SET=0x0100, OUT_CLR=0x0005 -> gpio_oe=0x00FF; gpio_o goes to 0xA5A5 and finally 0xA5A0 | 0x0100 = 0xA5A0 | 0x0100 (0xA5A0 with bit 8 set, i.e. 0xA5A0); OUT reads back 0xA5A0.
3. Write OUT=0x12345678 with bus_be=0b0010 -> OUT reads 0x00005600; bits >= NUM_PINS read 0.
4. RISE_EN=0x0001; drive gpio_i[0] 0→1 at edge N -> IN[0]=1 after N+2, PEND=0x0001 and irq=1 after N+3; W1C PEND=0x0001 -> irq drops the next cycle.
5. FALL_EN=0x0008; fall on pin 3 in the same cycle as a W1C of PEND bit 3 -> PEND[3] remains 1. gpio_i held 0xFFFF through reset release -> PEND stays 0.
6. Read offset 0x1C and offset 0x20 (ADDR_WIDTH=6 build) -> OUT_CLR read gives 0 with no error; 0x20 gives bus_err=1, bus_rd_valid=1, data 0. Assert rst_n low the cycle after a read request -> no rd_valid is seen and all outputs are 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO responder: register map, register index
// enum, bus data type and a byte-lane mask helper.
package gpio_pkg;

  // Bus data word
  typedef logic [31:0] gpio_data_t;

  // Register byte offsets inside the block's address region
  localparam int unsigned GPIO_MODE_OFS    = 32'h00;
  localparam int unsigned GPIO_OUT_OFS     = 32'h04;
  localparam int unsigned GPIO_IN_OFS      = 32'h08;
  localparam int unsigned GPIO_RISE_EN_OFS = 32'h0C;
  localparam int unsigned GPIO_FALL_EN_OFS = 32'h10;
  localparam int unsigned GPIO_PEND_OFS    = 32'h14;
  localparam int unsigned GPIO_OUT_SET_OFS = 32'h18;
  localparam int unsigned GPIO_OUT_CLR_OFS = 32'h1C;

  // Number of word registers; everything from this index upward is unmapped
  localparam int unsigned GPIO_NUM_REGS = 8;

  // Word index of each register (byte offset / 4)
  typedef enum logic [2:0] {
    GPIO_REG_MODE    = 3'(GPIO_MODE_OFS    >> 2),
    GPIO_REG_OUT     = 3'(GPIO_OUT_OFS     >> 2),
    GPIO_REG_IN      = 3'(GPIO_IN_OFS      >> 2),
    GPIO_REG_RISE_EN = 3'(GPIO_RISE_EN_OFS >> 2),
    GPIO_REG_FALL_EN = 3'(GPIO_FALL_EN_OFS >> 2),
    GPIO_REG_PEND    = 3'(GPIO_PEND_OFS    >> 2),
    GPIO_REG_OUT_SET = 3'(GPIO_OUT_SET_OFS >> 2),
    GPIO_REG_OUT_CLR = 3'(GPIO_OUT_CLR_OFS >> 2)
  } gpio_reg_e;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic gpio_data_t gpio_be_mask(input logic [3:0] be);
    gpio_data_t m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pin input conditioning: two-flop synchronizer, a "previous value" flop for
// edge detection, and a short post-reset mask so pins that are already high
// when reset releases do not look like rising edges.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [1:0]       mask_cnt_q, mask_cnt_d;
  logic             edge_ok;

  // Next-state: shift the pin pipeline, saturate the mask counter at 3
  always_comb begin
    meta_d     = async_i;
    sync_d     = meta_q;
    prev_d     = sync_q;
    mask_cnt_d = mask_cnt_q;
    if (mask_cnt_q != 2'd3) begin
      mask_cnt_d = mask_cnt_q + 2'd1;
    end
  end

  // State registers, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      prev_q     <= '0;
      mask_cnt_q <= 2'd0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      mask_cnt_q <= mask_cnt_d;
    end
  end

  // Edges are only reported once the pipeline has refilled after reset
  assign edge_ok  = (mask_cnt_q == 2'd3);
  assign sync_val = sync_q;

  // Per-pin edge detection against the previous synchronized value
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign rise[gi] = edge_ok &  sync_q[gi] & ~prev_q[gi];
    assign fall[gi] = edge_ok & ~sync_q[gi] &  prev_q[gi];
  end

endmodule

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO responder: pin direction/value registers, synchronized
// pin inputs, per-pin rise/fall interrupt pending bits with W1C, and a
// registered single-cycle read/error response.
module gpio_responder
  import gpio_pkg::*;
#(
  parameter int NUM_PINS   = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_en,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [3:0]            bus_be,
  input  logic [31:0]           bus_wr_data,
  output logic [31:0]           bus_rd_data,
  output logic                  bus_rd_valid,
  output logic                  bus_err,
  input  logic [NUM_PINS-1:0]   gpio_i,
  output logic [NUM_PINS-1:0]   gpio_o,
  output logic [NUM_PINS-1:0]   gpio_oe,
  output logic                  irq
);

  localparam int REG_IDX_W = $clog2(GPIO_NUM_REGS);

  // Register state
  logic [NUM_PINS-1:0] mode_q, mode_d;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
  logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0] pend_q, pend_d;

  // Registered pin drivers and bus response
  logic [NUM_PINS-1:0] gpio_o_q, gpio_o_d;
  logic [NUM_PINS-1:0] gpio_oe_q, gpio_oe_d;
  gpio_data_t          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  // Decode and datapath helpers
  gpio_reg_e           reg_sel;
  logic                addr_hi_zero;
  logic                mapped;
  logic                wr_req;
  logic                rd_req;
  gpio_data_t          be_mask;
  gpio_data_t          wr_bits;
  logic [NUM_PINS-1:0] be_pins;
  logic [NUM_PINS-1:0] wr_pins;
  logic [NUM_PINS-1:0] pend_clr;
  logic [NUM_PINS-1:0] pend_set;
  gpio_data_t          rd_word;
  logic                unused_bits;

  // Synchronized pins and edge strobes
  logic [NUM_PINS-1:0] sync_val;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;

  gpio_sync #(
    .WIDTH (NUM_PINS)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_i  (gpio_i),
    .sync_val (sync_val),
    .rise     (rise),
    .fall     (fall)
  );

  // Address bits above the register window must be zero to hit a register
  if (ADDR_WIDTH > REG_IDX_W + 2) begin : g_addr_hi
    assign addr_hi_zero = (bus_addr[ADDR_WIDTH-1:REG_IDX_W+2] == '0);
  end else begin : g_addr_nohi
    assign addr_hi_zero = 1'b1;
  end

  assign reg_sel = gpio_reg_e'(bus_addr[REG_IDX_W+1:2]);
  assign mapped  = addr_hi_zero;
  assign wr_req  = bus_en &  bus_we;
  assign rd_req  = bus_en & ~bus_we;

  // Byte-lane gating, then trim to the implemented pins
  assign be_mask = gpio_be_mask(bus_be);
  assign wr_bits = bus_wr_data & be_mask;
  assign be_pins = be_mask[NUM_PINS-1:0];
  assign wr_pins = wr_bits[NUM_PINS-1:0];

  // Byte-offset bits and lanes above NUM_PINS carry no information
  assign unused_bits = ^{bus_addr[1:0], wr_bits, be_mask};

  // Edge events enabled per pin
  assign pend_set = (rise & rise_en_q) | (fall & fall_en_q);

  // Register write decode; pending set has priority over W1C
  always_comb begin
    mode_d    = mode_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;
    if (wr_req && mapped) begin
      case (reg_sel)
        GPIO_REG_MODE:    mode_d    = (mode_q    & ~be_pins) | wr_pins;
        GPIO_REG_OUT:     out_d     = (out_q     & ~be_pins) | wr_pins;
        GPIO_REG_RISE_EN: rise_en_d = (rise_en_q & ~be_pins) | wr_pins;
        GPIO_REG_FALL_EN: fall_en_d = (fall_en_q & ~be_pins) | wr_pins;
        GPIO_REG_PEND:    pend_clr  = wr_pins;
        GPIO_REG_OUT_SET: out_d     = out_q | wr_pins;
        GPIO_REG_OUT_CLR: out_d     = out_q & ~wr_pins;
        default:          ;
      endcase
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  // Read mux; write-only and read-only-zero registers return 0
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      GPIO_REG_MODE:    rd_word = gpio_data_t'(mode_q);
      GPIO_REG_OUT:     rd_word = gpio_data_t'(out_q);
      GPIO_REG_IN:      rd_word = gpio_data_t'(sync_val);
      GPIO_REG_RISE_EN: rd_word = gpio_data_t'(rise_en_q);
      GPIO_REG_FALL_EN: rd_word = gpio_data_t'(fall_en_q);
      GPIO_REG_PEND:    rd_word = gpio_data_t'(pend_q);
      default:          rd_word = '0;
    endcase
  end

  // Response and pin-driver next state; data is forced to 0 when not valid
  always_comb begin
    rd_valid_d = rd_req;
    err_d      = bus_en & ~mapped;
    rd_data_d  = (rd_req && mapped) ? rd_word : '0;
    gpio_o_d   = out_q;
    gpio_oe_d  = mode_q;
  end

  // All state flops, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= '0;
      out_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pend_q     <= '0;
      gpio_o_q   <= '0;
      gpio_oe_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      out_q      <= out_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pend_q     <= pend_d;
      gpio_o_q   <= gpio_o_d;
      gpio_oe_q  <= gpio_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus_rd_data  = rd_data_q;
  assign bus_rd_valid = rd_valid_q;
  assign bus_err      = err_q;
  assign gpio_o       = gpio_o_q;
  assign gpio_oe      = gpio_oe_q;
  assign irq          = |pend_q;

endmodule
